branch_resolve_ctrl: RTL and testbench

Branch resolution controller for the EX stage of the pipelined core. It decodes the branch funct3 into the control and sign inputs of the branch comparator and turns the comparator flag into a taken/not-taken outcome. It checks that outcome against the fetch-time prediction, raises a registered flush/redirect on a misprediction, and maintains a small 2-bit-counter branch history table (BHT) that the IF stage reads for predictions.

---
 rtl/branch_resolve_ctrl_if.sv | 34 +++
 rtl/branch_resolve_ctrl.sv | 98 +++++++++
 tb/tb_branch_resolve_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// EX-stage branch resolution bus between the pipeline (master) and
// the branch resolution controller (slave).
interface branch_resolve_ctrl_if;
  logic        br_valid;
  logic [2:0]  funct3;
  logic [31:0] pc_ex;
  logic [31:0] target_ex;
  logic        is_compressed;
  logic        pred_taken_ex;
  logic        stall;
  logic [1:0]  cmp_ctrl;
  logic        cmp_sign;
  logic        bflag;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] mispredict_cnt;

  modport master (
    output br_valid, funct3, pc_ex, target_ex, is_compressed, pred_taken_ex,
           stall, bflag, pc_if,
    input  cmp_ctrl, cmp_sign, pred_taken_if, flush, redirect_pc, illegal_br,
           mispredict_cnt
  );

  modport slave (
    input  br_valid, funct3, pc_ex, target_ex, is_compressed, pred_taken_ex,
           stall, bflag, pc_if,
    output cmp_ctrl, cmp_sign, pred_taken_if, flush, redirect_pc, illegal_br,
           mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: comparator decode, taken/mispredict detection,
// registered flush/redirect and a 2-bit saturating-counter BHT for IF.
module branch_resolve_ctrl #(
  parameter int BHT_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_resolve_ctrl_if.slave bus
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic                 flush_q, flush_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [31:0]          mis_cnt_q, mis_cnt_d;

  logic [1:0]           ctrl;
  logic                 sign;
  logic                 taken;
  logic                 ill;
  logic                 res;
  logic                 mis;
  logic [31:0]          seq_pc;
  logic [BHT_IDX_W-1:0] idx_ex;
  logic [BHT_IDX_W-1:0] idx_if;
  logic [1:0]           ctr_ex;

  always_comb begin
    ctrl  = 2'b00;
    sign  = 1'b0;
    taken = 1'b0;
    ill   = 1'b0;
    case (bus.funct3)
      3'b000: taken = bus.bflag;
      3'b001: begin ctrl = 2'b01; taken = bus.bflag; end
      3'b100: begin ctrl = 2'b10; taken = bus.bflag; end
      3'b101: begin ctrl = 2'b10; taken = ~bus.bflag; end
      3'b110: begin ctrl = 2'b10; sign = 1'b1; taken = bus.bflag; end
      3'b111: begin ctrl = 2'b10; sign = 1'b1; taken = ~bus.bflag; end
      default: ill = 1'b1;
    endcase
  end

  assign bus.cmp_ctrl   = ctrl;
  assign bus.cmp_sign   = sign;
  assign bus.illegal_br = ill & bus.br_valid;

  // The EX instruction seen during a flush cycle is wrong-path and is dropped.
  assign res    = bus.br_valid & ~bus.stall & ~flush_q;
  assign mis    = res & (taken != bus.pred_taken_ex);
  assign seq_pc = bus.pc_ex + (bus.is_compressed ? 32'd2 : 32'd4);

  // Halfword-granular index because compressed branches can sit on 2-byte boundaries.
  assign idx_ex = bus.pc_ex[BHT_IDX_W:1];
  assign idx_if = bus.pc_if[BHT_IDX_W:1];
  assign ctr_ex = bht_q[idx_ex];

  assign bus.pred_taken_if = bht_q[idx_if][1];

  always_comb begin
    bht_d = bht_q;
    if (res) begin
      if (taken) begin
        if (ctr_ex != 2'b11) bht_d[idx_ex] = ctr_ex + 2'd1;
      end else begin
        if (ctr_ex != 2'b00) bht_d[idx_ex] = ctr_ex - 2'd1;
      end
    end
  end

  always_comb begin
    flush_d       = mis;
    redirect_pc_d = redirect_pc_q;
    if (mis) redirect_pc_d = taken ? bus.target_ex : seq_pc;
    mis_cnt_d     = mis_cnt_q + {31'd0, mis};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
      mis_cnt_q     <= 32'd0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
      bht_q         <= bht_d;
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: decode/mispredict vector table with a
// scoreboard for the registered outputs, plus hand-written BHT/flush/stall/reset sequences.
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if bus ();

  branch_resolve_ctrl #(.BHT_IDX_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        bflag;
    logic        pred;
    logic        cmpr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  ctrl;
    logic        sign;
    logic        ill;
    logic        mis;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        flush;
    logic [31:0] rpc;
    logic [31:0] cnt;
  } exp_t;

  vec_t vt [12];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.br_valid      = 1'b0;
    bus.funct3        = 3'b000;
    bus.pc_ex         = 32'd0;
    bus.target_ex     = 32'd0;
    bus.is_compressed = 1'b0;
    bus.pred_taken_ex = 1'b0;
    bus.stall         = 1'b0;
    bus.bflag         = 1'b0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic bf, input logic pr,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic c);
    bus.br_valid      = 1'b1;
    bus.funct3        = f3;
    bus.bflag         = bf;
    bus.pred_taken_ex = pr;
    bus.pc_ex         = pc;
    bus.target_ex     = tgt;
    bus.is_compressed = c;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    exp_t        e;
    logic [31:0] exp_rpc;
    logic [31:0] exp_cnt;

    // f3, bflag, pred, cmpr, pc, tgt, ctrl, sign, ill, mis, rpc
    vt[0]  = '{3'b101, 1'b1, 1'b0, 1'b0, 32'h200,      32'h300,      2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{3'b101, 1'b0, 1'b0, 1'b0, 32'h200,      32'h300,      2'b10, 1'b0, 1'b0, 1'b1, 32'h300};
    vt[2]  = '{3'b000, 1'b0, 1'b1, 1'b1, 32'h40,       32'h1000,     2'b00, 1'b0, 1'b0, 1'b1, 32'h42};
    vt[3]  = '{3'b000, 1'b0, 1'b1, 1'b0, 32'h40,       32'h1000,     2'b00, 1'b0, 1'b0, 1'b1, 32'h44};
    vt[4]  = '{3'b001, 1'b1, 1'b1, 1'b0, 32'h10,       32'h400,      2'b01, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[5]  = '{3'b100, 1'b1, 1'b0, 1'b0, 32'h20,       32'h500,      2'b10, 1'b0, 1'b0, 1'b1, 32'h500};
    vt[6]  = '{3'b110, 1'b0, 1'b1, 1'b0, 32'h24,       32'h540,      2'b10, 1'b1, 1'b0, 1'b1, 32'h28};
    vt[7]  = '{3'b111, 1'b0, 1'b0, 1'b0, 32'h30,       32'h600,      2'b10, 1'b1, 1'b0, 1'b1, 32'h600};
    vt[8]  = '{3'b011, 1'b1, 1'b0, 1'b0, 32'h34,       32'h700,      2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[9]  = '{3'b010, 1'b1, 1'b1, 1'b1, 32'h38,       32'h740,      2'b00, 1'b0, 1'b1, 1'b1, 32'h3a};
    vt[10] = '{3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h800,      2'b00, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[11] = '{3'b000, 1'b1, 1'b0, 1'b0, 32'h44,       32'hABCD0000, 2'b00, 1'b0, 1'b0, 1'b1, 32'hABCD0000};

    // Reset state
    idle();
    bus.pc_if = 32'h100;
    rst_n = 1'b0;
    #2;
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_redirect", bus.redirect_pc, 32'd0);
    check("rst_cnt", bus.mispredict_cnt, 32'd0);
    check("rst_pred_0x100", {31'd0, bus.pred_taken_if}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.pc_if = 32'(i) << 1;
      #1;
      check($sformatf("rst_pred_idx%0d", i), {31'd0, bus.pred_taken_if}, 32'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Decode / mispredict vector table with scoreboard
    exp_rpc = 32'd0;
    exp_cnt = 32'd0;
    for (int i = 0; i < 12; i++) begin
      set_br(vt[i].f3, vt[i].bflag, vt[i].pred, vt[i].pc, vt[i].tgt, vt[i].cmpr);
      #1;
      check($sformatf("v%0d_cmp_ctrl", i), {30'd0, bus.cmp_ctrl}, {30'd0, vt[i].ctrl});
      check($sformatf("v%0d_cmp_sign", i), {31'd0, bus.cmp_sign}, {31'd0, vt[i].sign});
      check($sformatf("v%0d_illegal", i), {31'd0, bus.illegal_br}, {31'd0, vt[i].ill});
      if (vt[i].mis) begin
        exp_cnt = exp_cnt + 32'd1;
        exp_rpc = vt[i].rpc;
      end
      sb.push_back('{vt[i].mis, exp_rpc, exp_cnt});
      tick();
      idle();
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL v%0d_scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_flush", i), {31'd0, bus.flush}, {31'd0, e.flush});
        check($sformatf("v%0d_redirect", i), bus.redirect_pc, e.rpc);
        check($sformatf("v%0d_cnt", i), bus.mispredict_cnt, e.cnt);
      end
      tick();
      check($sformatf("v%0d_flush_one_cycle", i), {31'd0, bus.flush}, 32'd0);
    end

    // BHT saturation at 0x80, same-cycle lookup returns pre-update value
    do_reset();
    bus.pc_if = 32'h80;
    set_br(3'b110, 1'b1, 1'b1, 32'h80, 32'h900, 1'b0);
    #1;
    check("bht_same_cycle_lookup", {31'd0, bus.pred_taken_if}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("bht_taken%0d_pred", k), {31'd0, bus.pred_taken_if}, 32'd1);
    end
    check("bht_no_flush_when_correct", {31'd0, bus.flush}, 32'd0);
    set_br(3'b110, 1'b0, 1'b0, 32'h80, 32'h900, 1'b0);
    tick();
    check("bht_dec1_pred", {31'd0, bus.pred_taken_if}, 32'd1);
    tick();
    check("bht_dec2_pred", {31'd0, bus.pred_taken_if}, 32'd0);
    idle();

    // Branch held in EX during the flush cycle is ignored; next one resolves
    do_reset();
    bus.pc_if = 32'h62;
    set_br(3'b000, 1'b1, 1'b0, 32'h60, 32'h700, 1'b0);
    tick();
    check("b2b_first_flush", {31'd0, bus.flush}, 32'd1);
    check("b2b_first_redirect", bus.redirect_pc, 32'h700);
    set_br(3'b000, 1'b1, 1'b0, 32'h62, 32'h900, 1'b0);
    tick();
    check("b2b_ignored_flush", {31'd0, bus.flush}, 32'd0);
    check("b2b_ignored_cnt", bus.mispredict_cnt, 32'd1);
    check("b2b_ignored_bht", {31'd0, bus.pred_taken_if}, 32'd0);
    check("b2b_redirect_hold", bus.redirect_pc, 32'h700);
    tick();
    check("b2b_next_flush", {31'd0, bus.flush}, 32'd1);
    check("b2b_next_redirect", bus.redirect_pc, 32'h900);
    check("b2b_next_cnt", bus.mispredict_cnt, 32'd2);
    check("b2b_next_bht", {31'd0, bus.pred_taken_if}, 32'd1);
    idle();
    tick();

    // Stall holds back a mispredicting branch; a live flush still drops under stall
    do_reset();
    set_br(3'b001, 1'b1, 1'b0, 32'h14, 32'hA00, 1'b0);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_flush", k), {31'd0, bus.flush}, 32'd0);
      check($sformatf("stall%0d_cnt", k), bus.mispredict_cnt, 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_flush", {31'd0, bus.flush}, 32'd1);
    check("unstall_redirect", bus.redirect_pc, 32'hA00);
    bus.stall = 1'b1;
    tick();
    check("flush_drops_under_stall", {31'd0, bus.flush}, 32'd0);
    check("stall_cnt_after", bus.mispredict_cnt, 32'd1);
    idle();

    // Reset while flush is high; BHT back to weakly not-taken (01, not 00)
    do_reset();
    bus.pc_if = 32'h80;
    set_br(3'b000, 1'b1, 1'b1, 32'h80, 32'hB00, 1'b0);
    tick();
    check("pre_rst_pred", {31'd0, bus.pred_taken_if}, 32'd1);
    set_br(3'b000, 1'b1, 1'b0, 32'h80, 32'hB00, 1'b0);
    tick();
    check("pre_rst_flush", {31'd0, bus.flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_flush", {31'd0, bus.flush}, 32'd0);
    check("midrst_redirect", bus.redirect_pc, 32'd0);
    check("midrst_cnt", bus.mispredict_cnt, 32'd0);
    check("midrst_pred", {31'd0, bus.pred_taken_if}, 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    set_br(3'b000, 1'b1, 1'b1, 32'h80, 32'hB00, 1'b0);
    tick();
    check("post_rst_bht_01", {31'd0, bus.pred_taken_if}, 32'd1);

    // illegal_br qualified by br_valid
    set_br(3'b011, 1'b0, 1'b0, 32'h90, 32'hC00, 1'b0);
    #1;
    check("illegal_valid", {31'd0, bus.illegal_br}, 32'd1);
    bus.br_valid = 1'b0;
    #1;
    check("illegal_not_valid", {31'd0, bus.illegal_br}, 32'd0);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
